downsample_2d_box: RTL and testbench
====================================

// Module: downsample_2d_box
// PURPOSE
//  Parametrised 2D decimator for disparity/pixel streams: reduces a raster frame by DEC in x and y.
//  Two run-time modes: point-sample (top-left pixel of each DECxDEC tile) or box average (tile mean).
//  Sits between the disparity filter output and the display/DMA path.
//  Adds multi-bit data width, per-frame mode select, SOF resync, a registered output with backpressure, and EOL/SOF tags.
// PARAMETERS
//  DEC       2    decimation factor in x and y; power of two, >=2
//  DATA_W    8    pixel width in bits
//  IN_WIDTH  240  input pixels per line; multiple of DEC
//  IN_HEIGHT 480  input lines per frame; multiple of DEC
// PORTS
//  clk        in   1       clock
//  reset_n    in   1       synchronous reset, active low
//  mode       in   1       0 = point-sample, 1 = box average; latched at frame start
//  in_data    in   DATA_W  input pixel
//  in_sof     in   1       first pixel of frame; qualified by in_valid
//  in_valid   in   1       input pixel valid
//  in_ready   out  1       input accepted when in_valid && in_ready
//  out_data   out  DATA_W  decimated pixel
//  out_sof    out  1       first output pixel of frame
//  out_eol    out  1       last output pixel of output line
//  out_valid  out  1       output valid
//  out_ready  in   1       downstream ready
// BEHAVIOUR
//  - One clock and one reset. On reset_n==0 at a clk edge:
//    - out_valid=0, out_data=0, out_sof=0, out_eol=0.
//    - Counters col, row, sub_x, sub_y are zeroed; mode_q=0.
//  - in_ready = !out_valid || out_ready. This is combinational; no input is accepted while an output is stalled.
//  - Counters advance on accept: col 0..IN_WIDTH-1 wraps and increments row; row 0..IN_HEIGHT-1 wraps.
//    sub_x = col mod DEC; sub_y = row mod DEC; ocol = col/DEC.
//  - Accepted pixel with in_sof=1: the pixel is treated as col=0,row=0 regardless of the counters (resync).
//    Partial tile sums are discarded.
//  - mode_q loads from mode on accept of any pixel at (0,0), whether from in_sof or from natural wrap.
//    mode changes mid-frame take effect next frame.
//  - Mode 0: emit on accept of a pixel with sub_x==0 && sub_y==0; out_data = that pixel.
//  - Mode 1:
//    - h_acc sums DEC pixels along x.
//    - At sub_x==DEC-1 the line buffer entry lb[ocol] (IN_WIDTH/DEC entries, DATA_W+2*log2(DEC) bits) is updated:
//      - sub_y==0: write h_sum.
//      - Otherwise: write lb[ocol]+h_sum.
//    - At sub_x==DEC-1 && sub_y==DEC-1, emit (lb[ocol]+h_sum) >> 2*log2(DEC).
//    - All sums are full width; no overflow is possible. Read-modify-write completes in the accept cycle.
//  - Latency: out_valid rises on the clk edge that accepts the triggering pixel (1 cycle).
//    out_data, out_sof, out_eol are registered with it.
//  - out_sof=1 for the output of tile (0,0). out_eol=1 for the output of ocol==IN_WIDTH/DEC-1.
//  - Holding: while out_valid && !out_ready, all out_* stay stable.
//  - Handshake: out_valid drops on the edge with out_ready==1 unless a new output is produced that same cycle.
//    Simultaneous accept of input and emit of output is allowed (full throughput).
//  - in_valid low: counters and accumulators hold.
//  - Reset mid-frame: the pending output is dropped. The next accepted pixel is (0,0) even without in_sof.
// CONFIGURATION
//  DOWNSAMPLE_ROUND_EN
//    defined: mode 1 output = (sum + 2^(2*log2(DEC)-1)) >> 2*log2(DEC), i.e. round half up.
//    undefined: mode 1 output = sum >> 2*log2(DEC), i.e. truncate.
//    Mode 0 is unaffected either way.
// TESTING (DEC=2, DATA_W=8, IN_WIDTH=8, IN_HEIGHT=4, pixel=col+8*row unless noted)
//  1 mode=0, one frame, out_ready=1:
//    -> outputs 0,2,4,6,16,18,20,22; out_sof on 0; out_eol on 6 and 22.
//  2 mode=1, same frame:
//    -> 4,6,8,10,20,22,24,26 (truncate).
//    With DOWNSAMPLE_ROUND_EN -> 5,7,9,11,21,23,25,27.
//  3 mode=1, all pixels 255 -> every output 255; no wrap.
//  4 out_ready low 5 cycles after first output:
//    -> out_valid and out_data held; in_ready=0; no pixel lost; sequence as in test 1.
//  5 in_sof asserted at col=3,row=1:
//    -> that pixel is treated as (0,0); next mode-0 output is that pixel with out_sof=1.
//  6 reset_n low 1 cycle mid-frame with out_valid=1, then mode toggled mid-frame:
//    -> out_valid=0 after the edge; restart at (0,0); the mode change applies only from the next frame.

Source files
------------

// File: rtl/downsample_2d_box.sv
// 2D DECxDEC decimator: point-sample or box-average, with a registered output and backpressure.
// Define DOWNSAMPLE_ROUND_EN to make box averages round half up instead of truncating.
module downsample_2d_box #(
    parameter int DEC       = 2,
    parameter int DATA_W    = 8,
    parameter int IN_WIDTH  = 240,
    parameter int IN_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int LOG2   = $clog2(DEC);
    localparam int SHIFT  = 2 * LOG2;
    localparam int OCOLS  = IN_WIDTH / DEC;
    localparam int COL_W  = $clog2(IN_WIDTH);
    localparam int ROW_W  = $clog2(IN_HEIGHT);
    localparam int OCOL_W = COL_W - LOG2;
    localparam int H_W    = DATA_W + LOG2;
    localparam int SUM_W  = DATA_W + SHIFT;

    logic [COL_W-1:0]  col_q, col_d, effCol;
    logic [ROW_W-1:0]  row_q, row_d, effRow;
    logic [H_W-1:0]    hAcc_q, hSum;
    logic [SUM_W-1:0]  lb_q [OCOLS];
    logic [SUM_W-1:0]  boxSum, roundSum;
    logic [LOG2-1:0]   subX, subY;
    logic [OCOL_W-1:0] ocol;
    logic              modeSel_q, modeEff, accept, emit, atOrigin, lastX, lastY;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic              outValid_q, outSof_q, outEol_q, outSof_d, outEol_d;

    assign in_ready  = !outValid_q || out_ready;
    assign out_data  = outData_q;
    assign out_sof   = outSof_q;
    assign out_eol   = outEol_q;
    assign out_valid = outValid_q;

    // A pixel flagged in_sof is forced to (0,0); restarting the sums at sub==0 discards partial tiles.
    always_comb begin
        accept   = in_valid && in_ready;
        effCol   = in_sof ? '0 : col_q;
        effRow   = in_sof ? '0 : row_q;
        subX     = effCol[LOG2-1:0];
        subY     = effRow[LOG2-1:0];
        ocol     = effCol[COL_W-1:LOG2];
        atOrigin = (effCol == '0) && (effRow == '0);
        modeEff  = atOrigin ? mode : modeSel_q;
        lastX    = (subX == LOG2'(DEC - 1));
        lastY    = (subY == LOG2'(DEC - 1));
        hSum     = ((subX == '0) ? '0 : hAcc_q) + H_W'(in_data);
        boxSum   = ((subY == '0) ? '0 : lb_q[ocol]) + SUM_W'(hSum);
`ifdef DOWNSAMPLE_ROUND_EN
        roundSum = boxSum + SUM_W'(1 << (SHIFT - 1));
`else
        roundSum = boxSum;
`endif
        emit      = modeEff ? (lastX && lastY) : ((subX == '0) && (subY == '0));
        outData_d = modeEff ? DATA_W'(roundSum >> SHIFT) : in_data;
        outSof_d  = (ocol == '0) && (effRow[ROW_W-1:LOG2] == '0);
        outEol_d  = (ocol == OCOL_W'(OCOLS - 1));
        col_d     = (effCol == COL_W'(IN_WIDTH - 1)) ? '0 : effCol + 1'b1;
        row_d     = effRow;
        if (effCol == COL_W'(IN_WIDTH - 1)) begin
            row_d = (effRow == ROW_W'(IN_HEIGHT - 1)) ? '0 : effRow + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            hAcc_q     <= '0;
            modeSel_q  <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSof_q   <= 1'b0;
            outEol_q   <= 1'b0;
        end else begin
            if (accept) begin
                col_q  <= col_d;
                row_q  <= row_d;
                hAcc_q <= hSum;
                if (atOrigin) begin
                    modeSel_q <= mode;
                end
            end
            if (accept && emit) begin
                outValid_q <= 1'b1;
                outData_q  <= outData_d;
                outSof_q   <= outSof_d;
                outEol_q   <= outEol_d;
            end else if (out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    // Line buffer holds vertical partial sums per output column; row 0 of each tile overwrites it.
    always_ff @(posedge clk) begin
        if (accept && lastX) begin
            lb_q[ocol] <= boxSum;
        end
    end

endmodule

// File: tb/tb_downsample_2d_box.sv
// Directed self-checking bench for downsample_2d_box at DEC=2, 8x4 frames.
// Expected box averages follow DOWNSAMPLE_ROUND_EN when it is defined.
module tb_downsample_2d_box;

    logic       clk = 1'b0;
    logic       resetN;
    logic       mode;
    logic [7:0] inData;
    logic       inSof;
    logic       inValid;
    logic       inReady;
    logic [7:0] outData;
    logic       outSof;
    logic       outEol;
    logic       outValid;
    logic       outReady;

    int checks = 0;
    int errors = 0;
    logic [9:0] outQ [$];

    downsample_2d_box #(.DEC(2), .DATA_W(8), .IN_WIDTH(8), .IN_HEIGHT(4)) dut (
        .clk(clk), .reset_n(resetN), .mode(mode),
        .in_data(inData), .in_sof(inSof), .in_valid(inValid), .in_ready(inReady),
        .out_data(outData), .out_sof(outSof), .out_eol(outEol),
        .out_valid(outValid), .out_ready(outReady)
    );

    always #5 clk = ~clk;

    // Record every output transfer as {sof, eol, data}.
    always @(negedge clk) begin
        if (outValid && outReady) outQ.push_back({outSof, outEol, outData});
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] d, input logic s);
        logic rdy;
        int n = 0;
        @(negedge clk);
        inData = d; inSof = s; inValid = 1'b1;
        rdy = inReady;
        @(posedge clk);
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = inReady;
            @(posedge clk);
            n++;
        end
        #1;
        inValid = 1'b0; inSof = 1'b0;
        if (!rdy) begin
            checks++; errors++;
            $error("[TB] FAIL accept pixel %0d: in_ready stayed 0, required 1", d);
        end
    endtask

    task automatic sendFrame(input bit allMax, input bit withSof);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                applyStimulus(allMax ? 8'd255 : 8'(c + 8 * r), withSof && r == 0 && c == 0);
    endtask

    task automatic checkSignal(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int expData, input bit expSof, input bit expEol);
        logic [9:0] got;
        logic [9:0] exp;
        int n = 0;
        while (outQ.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        exp = {expSof, expEol, 8'(expData)};
        if (outQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s: observed no output expected data=%0d", tag, expData);
        end else begin
            got = outQ.pop_front();
            assert (got === exp) else begin
                errors++;
                $error("[TB] FAIL %s: observed sof=%0b eol=%0b data=%0d expected sof=%0b eol=%0b data=%0d",
                       tag, got[9], got[8], got[7:0], expSof, expEol, expData);
            end
        end
    endtask

    task automatic checkFrame(input string tag, input int exp [8]);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("%s[%0d]", tag, i), exp[i], i == 0, i == 3 || i == 7);
    endtask

    int expPoint [8] = '{0, 2, 4, 6, 16, 18, 20, 22};
`ifdef DOWNSAMPLE_ROUND_EN
    int expBox [8] = '{5, 7, 9, 11, 21, 23, 25, 27};
`else
    int expBox [8] = '{4, 6, 8, 10, 20, 22, 24, 26};
`endif
    int expMax [8] = '{255, 255, 255, 255, 255, 255, 255, 255};

    initial begin
        resetN = 1'b0; mode = 1'b0; inData = '0; inSof = 1'b0; inValid = 1'b0; outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkSignal("reset out_valid", outValid, 0);
        checkSignal("reset out_data", outData, 0);
        checkSignal("reset out_sof", outSof, 0);
        checkSignal("reset out_eol", outEol, 0);
        checkSignal("reset in_ready", inReady, 1);
        resetN = 1'b1;

        $display("[TB] point-sample frame");
        sendFrame(1'b0, 1'b1);
        checkFrame("point", expPoint);

        $display("[TB] box-average frame via natural wrap");
        mode = 1'b1;
        sendFrame(1'b0, 1'b0);
        checkFrame("box", expBox);

        $display("[TB] box-average saturated frame");
        sendFrame(1'b1, 1'b0);
        checkFrame("boxmax", expMax);

        $display("[TB] backpressure stall");
        mode = 1'b0;
        fork
            sendFrame(1'b0, 1'b1);
            begin
                int n = 0;
                while (!outValid && n < 100) begin
                    @(posedge clk); #1; n++;
                end
                checkSignal("stall first valid", outValid, 1);
                outReady = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkSignal("stall out_valid", outValid, 1);
                    checkSignal("stall out_data", outData, 0);
                    checkSignal("stall out_sof", outSof, 1);
                    checkSignal("stall in_ready", inReady, 0);
                end
                @(posedge clk); #1;
                outReady = 1'b1;
            end
        join
        checkFrame("stall", expPoint);

        $display("[TB] in_sof resync at col 3 row 1");
        for (int c = 0; c < 8; c++) applyStimulus(8'(c), c == 0);
        for (int c = 0; c < 3; c++) applyStimulus(8'(8 + c), 1'b0);
        applyStimulus(8'd100, 1'b1);
        applyStimulus(8'd101, 1'b0);
        checkOutput("resync row0[0]", 0, 1'b1, 1'b0);
        checkOutput("resync row0[1]", 2, 1'b0, 1'b0);
        checkOutput("resync row0[2]", 4, 1'b0, 1'b0);
        checkOutput("resync row0[3]", 6, 1'b0, 1'b1);
        checkOutput("resync pixel", 100, 1'b1, 1'b0);

        $display("[TB] reset with pending output");
        outReady = 1'b0;
        applyStimulus(8'd102, 1'b0);
        checkSignal("pending out_valid", outValid, 1);
        checkSignal("pending out_data", outData, 102);
        resetN = 1'b0;
        @(posedge clk); #1;
        checkSignal("midreset out_valid", outValid, 0);
        checkSignal("midreset out_data", outData, 0);
        resetN = 1'b1;
        outReady = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                if (r == 0 && c == 4) mode = 1'b1;
                applyStimulus(8'(c + 8 * r), 1'b0);
            end
        checkFrame("postreset", expPoint);
        sendFrame(1'b0, 1'b0);
        checkFrame("nextmode", expBox);
        repeat (3) @(negedge clk);
        checkSignal("no extra outputs", outQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
